// File: rtl/llc_output_encoder.sv
// LLC transmit-side encoder: per-channel FIFOs that queue {tag,set}/msg/id entries
// from the core and present them on rsp, fwd and mem_req valid/ready interfaces.
module llc_output_encoder #(
    parameter int DEPTH    = 2,
    parameter int TAG_BITS = 12,
    parameter int SET_BITS = 8,
    parameter int MSG_BITS = 5,
    parameter int ID_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         send_rsp,
    input  logic                         send_fwd,
    input  logic                         send_mem,
    input  logic [TAG_BITS-1:0]          send_tag,
    input  logic [SET_BITS-1:0]          send_set,
    input  logic [MSG_BITS-1:0]          send_msg,
    input  logic [ID_BITS-1:0]           send_id,
    output logic                         rsp_avail,
    output logic                         fwd_avail,
    output logic                         mem_avail,
    output logic                         llc_rsp_out_valid_int,
    input  logic                         llc_rsp_out_ready_int,
    output logic                         llc_fwd_out_valid_int,
    input  logic                         llc_fwd_out_ready_int,
    output logic                         llc_mem_req_valid_int,
    input  logic                         llc_mem_req_ready_int,
    output logic [TAG_BITS+SET_BITS-1:0] rsp_out_addr,
    output logic [TAG_BITS+SET_BITS-1:0] fwd_out_addr,
    output logic [TAG_BITS+SET_BITS-1:0] mem_req_addr,
    output logic [MSG_BITS-1:0]          rsp_out_msg,
    output logic [MSG_BITS-1:0]          fwd_out_msg,
    output logic [MSG_BITS-1:0]          mem_req_msg,
    output logic [ID_BITS-1:0]           rsp_out_id,
    output logic [ID_BITS-1:0]           fwd_out_id,
    output logic [ID_BITS-1:0]           mem_req_id,
    output logic                         out_idle,
    output logic                         overflow_err
);

    localparam int AW = TAG_BITS + SET_BITS;
    localparam int EW = AW + MSG_BITS + ID_BITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [EW-1:0] entry_in;
    logic [2:0]    send_vec;
    logic [2:0]    ready_vec;
    logic [2:0]    valid_vec;
    logic [2:0]    avail_vec;
    logic [2:0]    ovf_vec;
    logic [EW-1:0] head_vec [3];

    // Entry layout: {addr = {tag,set}, msg, id}; shared by every channel pushed this cycle.
    assign entry_in  = {send_tag, send_set, send_msg, send_id};
    assign send_vec  = {send_mem, send_fwd, send_rsp};
    assign ready_vec = {llc_mem_req_ready_int, llc_fwd_out_ready_int, llc_rsp_out_ready_int};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [EW-1:0] mem_q [DEPTH];
            logic [EW-1:0] mem_d [DEPTH];
            logic [PW-1:0] wr_ptr_q, wr_ptr_d;
            logic [PW-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0] count_q, count_d;
            logic          ovf_q, ovf_d;
            logic          avail;
            logic          push;
            logic          pop;

            // Availability looks only at the registered count, so a full FIFO
            // rejects a push even when it is popping in the same cycle.
            assign avail = (count_q < CW'(DEPTH));

            always_comb begin
                push     = send_vec[gi] && avail;
                pop      = (count_q != '0) && ready_vec[gi];
                mem_d    = mem_q;
                if (push) begin
                    mem_d[wr_ptr_q] = entry_in;
                end
                wr_ptr_d = wr_ptr_q + PW'(push);
                rd_ptr_d = rd_ptr_q + PW'(pop);
                count_d  = count_q + CW'(push) - CW'(pop);
                ovf_d    = ovf_q | (send_vec[gi] & ~avail);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    ovf_q    <= 1'b0;
                end else begin
                    mem_q    <= mem_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    ovf_q    <= ovf_d;
                end
            end

            assign valid_vec[gi] = (count_q != '0);
            assign avail_vec[gi] = avail;
            assign ovf_vec[gi]   = ovf_q;
            assign head_vec[gi]  = mem_q[rd_ptr_q];
        end
    endgenerate

    assign rsp_avail    = avail_vec[0];
    assign fwd_avail    = avail_vec[1];
    assign mem_avail    = avail_vec[2];
    assign out_idle     = ~|valid_vec;
    assign overflow_err = |ovf_vec;

    assign llc_rsp_out_valid_int = valid_vec[0];
    assign llc_fwd_out_valid_int = valid_vec[1];
    assign llc_mem_req_valid_int = valid_vec[2];

    assign {rsp_out_addr, rsp_out_msg, rsp_out_id} = head_vec[0];
    assign {fwd_out_addr, fwd_out_msg, fwd_out_id} = head_vec[1];
    assign {mem_req_addr, mem_req_msg, mem_req_id} = head_vec[2];

endmodule

// File: tb/tb_llc_output_encoder.sv
// Directed bench for llc_output_encoder: encode, latency, backpressure, overflow,
// wrap under simultaneous push/pop, stall hold, multi-send and mid-transfer reset.
module tb_llc_output_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_rsp, send_fwd, send_mem;
    logic [11:0] send_tag;
    logic [7:0]  send_set;
    logic [4:0]  send_msg;
    logic [3:0]  send_id;
    logic        rsp_avail, fwd_avail, mem_avail;
    logic        rsp_valid, fwd_valid, mem_valid;
    logic        rsp_ready, fwd_ready, mem_ready;
    logic [19:0] rsp_out_addr, fwd_out_addr, mem_req_addr;
    logic [4:0]  rsp_out_msg, fwd_out_msg, mem_req_msg;
    logic [3:0]  rsp_out_id, fwd_out_id, mem_req_id;
    logic        out_idle, overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    llc_output_encoder #(
        .DEPTH(2), .TAG_BITS(12), .SET_BITS(8), .MSG_BITS(5), .ID_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .send_rsp(send_rsp), .send_fwd(send_fwd), .send_mem(send_mem),
        .send_tag(send_tag), .send_set(send_set), .send_msg(send_msg), .send_id(send_id),
        .rsp_avail(rsp_avail), .fwd_avail(fwd_avail), .mem_avail(mem_avail),
        .llc_rsp_out_valid_int(rsp_valid), .llc_rsp_out_ready_int(rsp_ready),
        .llc_fwd_out_valid_int(fwd_valid), .llc_fwd_out_ready_int(fwd_ready),
        .llc_mem_req_valid_int(mem_valid), .llc_mem_req_ready_int(mem_ready),
        .rsp_out_addr(rsp_out_addr), .fwd_out_addr(fwd_out_addr), .mem_req_addr(mem_req_addr),
        .rsp_out_msg(rsp_out_msg), .fwd_out_msg(fwd_out_msg), .mem_req_msg(mem_req_msg),
        .rsp_out_id(rsp_out_id), .fwd_out_id(fwd_out_id), .mem_req_id(mem_req_id),
        .out_idle(out_idle), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic payload(input logic [11:0] t, input logic [7:0] s,
                           input logic [4:0] m, input logic [3:0] i);
        send_tag = t; send_set = s; send_msg = m; send_id = i;
    endtask

    initial begin
        rst = 1'b0;
        send_rsp = 0; send_fwd = 0; send_mem = 0;
        rsp_ready = 0; fwd_ready = 0; mem_ready = 0;
        payload(12'h0, 8'h0, 5'h0, 4'h0);
        tick(); tick();

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_avail", 32'({rsp_avail, fwd_avail, mem_avail}), 32'h7);
        check("rst_idle", 32'(out_idle), 32'd1);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_rsp_addr", 32'(rsp_out_addr), 32'h0);
        rst = 1'b1;
        tick();

        // Encode and latency
        rsp_ready = 1;
        send_rsp = 1;
        payload(12'h3A5, 8'h12, 5'd2, 4'd1);
        check("enc_no_comb_valid", 32'(rsp_valid), 32'd0);
        tick();
        send_rsp = 0;
        check("enc_valid", 32'(rsp_valid), 32'd1);
        check("enc_addr", 32'(rsp_out_addr), 32'h3A512);
        check("enc_msg", 32'(rsp_out_msg), 32'd2);
        check("enc_id", 32'(rsp_out_id), 32'd1);
        check("enc_idle_busy", 32'(out_idle), 32'd0);
        tick();
        check("enc_valid_one_cycle", 32'(rsp_valid), 32'd0);
        check("enc_idle_after", 32'(out_idle), 32'd1);

        // Backpressure and overflow on fwd
        fwd_ready = 0;
        send_fwd = 1;
        payload(12'h00A, 8'h0A, 5'd3, 4'd3);
        tick();
        check("bp_avail_after1", 32'(fwd_avail), 32'd1);
        check("bp_valid_after1", 32'(fwd_valid), 32'd1);
        payload(12'h00B, 8'h0B, 5'd4, 4'd4);
        tick();
        check("bp_avail_after2", 32'(fwd_avail), 32'd0);
        check("bp_ovf_before", 32'(overflow_err), 32'd0);
        payload(12'h00C, 8'h0C, 5'd5, 4'd5);
        tick();
        send_fwd = 0;
        check("bp_ovf_set", 32'(overflow_err), 32'd1);
        check("bp_avail_full", 32'(fwd_avail), 32'd0);
        check("bp_head_A", 32'(fwd_out_addr), 32'h00A0A);
        tick();
        check("bp_hold_A", 32'(fwd_out_addr), 32'h00A0A);
        fwd_ready = 1;
        tick();
        check("bp_head_B", 32'(fwd_out_addr), 32'h00B0B);
        check("bp_msg_B", 32'(fwd_out_msg), 32'd4);
        check("bp_valid_B", 32'(fwd_valid), 32'd1);
        check("bp_avail_back", 32'(fwd_avail), 32'd1);
        tick();
        check("bp_drained", 32'(fwd_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow_err), 32'd1);

        // Push+pop at count=1 across pointer wrap
        rsp_ready = 1;
        send_rsp = 1;
        payload(12'h100, 8'h40, 5'd0, 4'd0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            payload(12'(12'h100 + k), 8'(8'h40 + k), 5'(k), 4'(k));
            tick();
            check($sformatf("pp_valid_%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("pp_avail_%0d", k), 32'(rsp_avail), 32'd1);
            check($sformatf("pp_addr_%0d", k), 32'(rsp_out_addr),
                  32'({12'(12'h100 + k), 8'(8'h40 + k)}));
            check($sformatf("pp_id_%0d", k), 32'(rsp_out_id), 32'(k));
        end
        send_rsp = 0;
        tick();
        check("pp_drained", 32'(rsp_valid), 32'd0);

        // Stall hold on mem_req while other channels are busy
        mem_ready = 0;
        send_mem = 1;
        payload(12'hABC, 8'h5A, 5'd7, 4'd9);
        tick();
        send_mem = 0;
        send_rsp = 1;
        send_fwd = 1;
        for (int k = 0; k < 5; k++) begin
            payload(12'(12'h200 + k), 8'(8'h10 + k), 5'd1, 4'd2);
            tick();
            check($sformatf("st_valid_%0d", k), 32'(mem_valid), 32'd1);
            check($sformatf("st_addr_%0d", k), 32'(mem_req_addr), 32'hABC5A);
            check($sformatf("st_msg_%0d", k), 32'(mem_req_msg), 32'd7);
            check($sformatf("st_id_%0d", k), 32'(mem_req_id), 32'd9);
        end
        send_rsp = 0;
        send_fwd = 0;
        mem_ready = 1;
        tick();
        check("st_mem_popped", 32'(mem_valid), 32'd0);
        check("st_idle", 32'(out_idle), 32'd1);

        // Multi-send with one shared payload
        rsp_ready = 0; fwd_ready = 0; mem_ready = 0;
        send_rsp = 1; send_fwd = 1; send_mem = 1;
        payload(12'h5C3, 8'hE7, 5'd17, 4'd6);
        tick();
        send_rsp = 0; send_fwd = 0; send_mem = 0;
        check("ms_valids", 32'({rsp_valid, fwd_valid, mem_valid}), 32'h7);
        check("ms_rsp_addr", 32'(rsp_out_addr), 32'h5C3E7);
        check("ms_fwd_addr", 32'(fwd_out_addr), 32'h5C3E7);
        check("ms_mem_addr", 32'(mem_req_addr), 32'h5C3E7);
        check("ms_msgs", 32'({rsp_out_msg, fwd_out_msg, mem_req_msg}), 32'({5'd17, 5'd17, 5'd17}));
        check("ms_ids", 32'({rsp_out_id, fwd_out_id, mem_req_id}), 32'h666);
        rsp_ready = 1; fwd_ready = 1; mem_ready = 1;
        tick();
        check("ms_idle", 32'(out_idle), 32'd1);

        // Asynchronous reset with an entry queued
        rsp_ready = 0;
        send_rsp = 1;
        payload(12'h777, 8'h77, 5'd3, 4'd3);
        tick();
        send_rsp = 0;
        check("ar_queued", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(rsp_valid), 32'd0);
        check("ar_idle", 32'(out_idle), 32'd1);
        check("ar_avail", 32'(rsp_avail), 32'd1);
        check("ar_ovf", 32'(overflow_err), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("ar_stays_empty", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
